// File: rtl/uc_pkg.sv
// Shared types and pin map for the uc_tx UART transmitter.
package uc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int TX_VALID_BIT = 0;
  localparam int TX_LINE_BIT  = 1;
  localparam int BUSY_BIT     = 2;

  localparam logic [7:0] UIO_OE_MASK = 8'b0000_0110;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tt_um_uc_tx_if.sv
// Byte-in / serial-out link between the pin wrapper and the transmitter core.
interface tt_um_uc_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_line;
  logic       busy;
  logic [7:0] frame_cnt;

  modport master (
    output tx_valid, tx_data,
    input  tx_line, busy, frame_cnt
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_line, busy, frame_cnt
  );
endinterface

// File: rtl/tt_um_uc_tx_core.sv
// UART frame serialiser FSM; tx follows the state register, so one cycle after accept.
// Define UC_TX_PARITY_EN to add an even-parity bit between data bit 7 and stop.
module tt_um_uc_tx_core
  import uc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_um_uc_tx_if.slave bus
);

  tx_state_e  state_q, state_d;
  logic [7:0] shreg_q;
  logic [2:0] bit_idx_q;
  logic [7:0] frame_cnt_q;
  logic       accept;
  logic       bit_tick;
  logic       tx_line;
`ifdef UC_TX_PARITY_EN
  logic       par_q;
`endif

  uc_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  // STOP hands straight to START when tx_valid is waiting, so back-to-back
  // frames keep a full-length stop bit with no idle gap.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx_valid) begin
          state_d = START;
          accept  = 1'b1;
        end
      end
      START:  if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick && bit_idx_q == 3'd7) begin
`ifdef UC_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (bit_tick) state_d = STOP;
      STOP: begin
        if (bit_tick) begin
          if (bus.tx_valid) begin
            state_d = START;
            accept  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    case (state_q)
      START:  tx_line = 1'b0;
      DATA:   tx_line = shreg_q[0];
`ifdef UC_TX_PARITY_EN
      PARITY: tx_line = par_q;
`endif
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      frame_cnt_q <= '0;
`ifdef UC_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        shreg_q   <= bus.tx_data;
        bit_idx_q <= '0;
`ifdef UC_TX_PARITY_EN
        par_q     <= even_parity(bus.tx_data);
`endif
      end else if (state_q == DATA && bit_tick) begin
        shreg_q   <= {1'b0, shreg_q[7:1]};
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (state_q == STOP && bit_tick) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign bus.tx_line   = tx_line;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: rtl/uc_baud_gen.sv
// Bit-time counter: bit_tick pulses on the last cycle of each CLKS_PER_BIT-cycle bit.
// restart holds the count at zero so the first bit after it is full length.
module uc_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign bit_tick = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_uc_tx.sv
// Tiny Tapeout pin wrapper for the UART transmitter; uo_out counts completed frames.
// Optional even parity is enabled by defining UC_TX_PARITY_EN.
module tt_um_uc_tx
  import uc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  tt_um_uc_tx_if link ();

  assign link.tx_valid = uio_in[TX_VALID_BIT];
  assign link.tx_data  = ui_in;

  tt_um_uc_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (link.slave)
  );

  always_comb begin
    uio_out              = '0;
    uio_out[TX_LINE_BIT] = link.tx_line;
    uio_out[BUSY_BIT]    = link.busy;
  end

  assign uio_oe = UIO_OE_MASK;
  assign uo_out = link.frame_cnt;

  // ena is power-good only; spare uio inputs have no function.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_uc_tx.sv
// Scoreboard bench for tt_um_uc_tx: expected frames are queued at stimulus time and
// compared cycle-by-cycle against the tx line by an independent monitor.
module tb_tt_um_uc_tx;

  localparam int CPB = 4;
`ifdef UC_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int F = NB * CPB;
  localparam logic [63:0] FMASK = (64'd1 << F) - 64'd1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [6:0] junk  = '0;
  logic [7:0] uio_in, uio_out, uio_oe, uo_out;

  tt_um_uc_tx_if bus ();

  assign uio_in        = {junk, bus.tx_valid};
  assign bus.tx_line   = uio_out[1];
  assign bus.busy      = uio_out[2];
  assign bus.frame_cnt = uo_out;

  tt_um_uc_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (bus.tx_data),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a UART frame is a list of bit levels, each lasting CPB clocks.
  function automatic logic [63:0] frame_wave(input logic [7:0] b);
    logic [10:0] bits;
    logic [63:0] w;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    if (PAR) bits[9] = ^b;
    w = '0;
    for (int k = 0; k < F; k++) w[k] = bits[k / CPB];
    return w;
  endfunction

  // Monitor
  logic        rst_q = 1'b0;
  bit          seen_rst = 1'b0;
  bit          capturing = 1'b0;
  bit          pend = 1'b0;
  int          ncap = 0;
  logic [63:0] smp, bsy;
  logic [7:0]  exp_cnt = '0;

  always @(posedge clk) rst_q <= rst_n;

  always @(negedge clk) begin
    if (rst_q === 1'b0) begin
      if (seen_rst) check("reset_outputs", {bus.tx_line, bus.busy, uo_out}, {1'b1, 1'b0, 8'h00});
      seen_rst  = 1'b1;
      capturing = 1'b0;
      pend      = 1'b0;
      exp_q.delete();
      exp_cnt   = '0;
    end else if (seen_rst) begin
      check("uio_out_spare", uio_out & 8'hF9, 64'd0);
      if (pend) begin
        check("frame_count", uo_out, exp_cnt);
        pend = 1'b0;
      end
      if (capturing) begin
        smp[ncap] = bus.tx_line;
        bsy[ncap] = bus.busy;
        ncap++;
      end else if (bus.busy === 1'b1) begin
        capturing = 1'b1;
        smp = '0;
        bsy = '0;
        smp[0] = bus.tx_line;
        bsy[0] = bus.busy;
        ncap = 1;
      end else begin
        check("idle_tx", bus.tx_line, 64'd1);
      end
      if (capturing && ncap == F) begin
        capturing = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual_wave=%0h required=none at %0t", smp, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("frame_bits", smp, frame_wave(e));
          check("frame_busy", bsy, FMASK);
        end
        exp_cnt = exp_cnt + 8'd1;
        pend = 1'b1;
      end
    end
  end

  // Stimulus
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_pulse(input logic [7:0] b);
    wait_idle();
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  task automatic send_b2b(input logic [7:0] b1, input logic [7:0] b2);
    wait_idle();
    bus.tx_data  = b1;
    bus.tx_valid = 1'b1;
    exp_q.push_back(b1);
    @(negedge clk);
    bus.tx_data = b2;
    exp_q.push_back(b2);
    repeat (F) @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  task automatic stray_pulse(input int after);
    repeat (after) @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'($urandom);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_oe", uio_oe, 64'h06);
    check("idle_state", {bus.tx_line, bus.busy, uo_out}, {1'b1, 1'b0, 8'h00});

    send_pulse(8'hA5);
    wait_idle();
    check("count_after_a5", uo_out, 64'd1);

    send_b2b(8'h00, 8'hFF);
    wait_idle();
    check("count_after_b2b", uo_out, 64'd3);

    send_pulse(8'h96);
    repeat (9) @(negedge clk);
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_idle();
    check("count_after_ignored", uo_out, 64'd4);

    send_pulse(8'h01);
    wait_idle();

    // Abort a 0x55 frame at cycle 15 while tx_valid is also high.
    send_pulse(8'h55);
    repeat (14) @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h3C;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", {bus.tx_line, bus.busy, uo_out}, {1'b1, 1'b0, 8'h00});
    rst_n = 1'b1;
    bus.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("no_accept_in_reset", {bus.busy, uo_out}, {1'b0, 8'h00});
    send_pulse(8'h55);
    wait_idle();
    check("count_after_abort", uo_out, 64'd1);

    // Random traffic, long enough to wrap the frame counter.
    for (int n = 0; n < 260; n++) begin
      int kind;
      junk = 7'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        send_b2b(8'($urandom), 8'($urandom));
      end else if (kind == 1) begin
        send_pulse(8'($urandom));
        stray_pulse($urandom_range(1, F - 3));
      end else begin
        send_pulse(8'($urandom));
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 64'd0);
    check("final_count_matches", uo_out, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tt_um_uc_tx.md
TT_UM_UC_TX -- requirements
Module: tt_um_uc_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ena  input  1  power-good; ignored.
REQ-005 SHALL have port ui_in  input  8  transmit data byte.
REQ-006 SHALL have port uio_in  input  8  bit 0 = tx_valid; bits 7:1 unused.
REQ-007 SHALL have port uio_out  output  8  bit 1 = tx line, bit 2 = busy, all other bits 0.
REQ-008 SHALL have port uio_oe  output  8  constant 8'b0000_0110.
REQ-009 SHALL have port uo_out  output  8  count of completed frames, wrapping.

Function
REQ-010 SHALL serialise UART frames: start bit 0, 8 data bits LSB first, optional parity, one stop bit 1.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA after one bit time; DATA->PARITY/STOP after bit 7; PARITY->STOP after one bit time; STOP->IDLE after one bit time.
REQ-012 SHALL accept a byte when tx_valid=1 in IDLE (ready = not busy), capturing ui_in into a shift register on that edge.
REQ-013 SHALL drive tx line low starting the cycle after the accept edge (one-cycle latency).
REQ-014 SHALL hold every bit for exactly CLKS_PER_BIT cycles using a bit-time counter reloaded at each bit boundary.
REQ-015 SHALL assert busy from the cycle tx goes low through the last stop-bit cycle; busy=0 only in IDLE.
REQ-016 SHALL ignore tx_valid while busy; no queuing, ui_in changes mid-frame have no effect.
REQ-017 SHALL, with tx_valid held high, start the next frame the cycle after STOP ends (back-to-back, full stop bit preserved).
REQ-018 SHALL increment uo_out on the last STOP cycle, 8-bit wrap 255->0.
REQ-019 SHALL keep tx line 1 in IDLE.

Reset
REQ-020 SHALL, on rst_n=0 at a clock edge, go to IDLE, tx=1, busy=0, uo_out=0, counters and shift register cleared.
REQ-021 SHALL abort any frame in progress on reset; tx returns high the edge reset is sampled; no partial frame resumes.
REQ-022 SHALL not accept tx_valid during the cycle rst_n=0.

Configuration
REQ-023 SHALL, with macro UC_TX_PARITY_EN defined, insert an even-parity bit (XOR of data bits) between bit 7 and stop; frame = 11 bit times.
REQ-024 SHALL, without UC_TX_PARITY_EN, skip PARITY (DATA->STOP directly); frame = 10 bit times.

Structure
REQ-025 SHALL place state enum, uio pin indices (TX_VALID_BIT=0, TX_LINE_BIT=1, BUSY_BIT=2) and UIO_OE_MASK in shared package uc_pkg.
REQ-026 SHALL implement bit-timing in sub-module uc_baud_gen (counter, restart input, one-cycle bit_tick output).

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL check: reset, idle 20 cycles -> tx=1, busy=0, uo_out=0, uio_oe=0x06.
REQ-028 SHALL check: ui_in=0xA5, tx_valid pulse 1 cycle -> tx bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy high 40 cycles; uo_out=1.
REQ-029 SHALL check: tx_valid held high, ui_in=0x00 then 0xFF -> two back-to-back frames, stop bit exactly 4 cycles, uo_out=2.
REQ-030 SHALL check: tx_valid pulse at cycle 10 of a frame with ui_in=0x3C -> ignored, frame data unchanged, uo_out increments once.
REQ-031 SHALL check: rst_n low at cycle 15 of a 0x55 frame -> tx=1, busy=0 next edge, uo_out=0, next accept sends a clean frame.
REQ-032 SHALL check with UC_TX_PARITY_EN: ui_in=0xA5 -> parity bit 0, ui_in=0x01 -> parity bit 1, busy 44 cycles.
